// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache.
// One line transaction is latched at a time; ties alternate round-robin.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,
    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last_grant_d;
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic [ADDR_WIDTH-1:0] r_pmem_address;
    logic [LINE_WIDTH-1:0] r_pmem_wdata;
    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_grant_i;
    logic                  w_grant_d;

    assign w_i_req = icache_pmem_read;
    assign w_d_req = dcache_pmem_read | dcache_pmem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // On a tie the requester not served last wins; after reset that is D.
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    if (r_last_grant_d) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (w_i_req) begin
                    w_grant_i = 1'b1;
                end else if (w_d_req) begin
                    w_grant_d = 1'b1;
                end
                if (w_grant_i) begin
                    w_next_state = SERVE_I;
                end else if (w_grant_d) begin
                    w_next_state = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // A D request with both read and write set is a write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_last_grant_d <= 1'b0;
        end else if (w_grant_d) begin
            r_pmem_address <= dcache_pmem_address;
            r_pmem_wdata   <= dcache_pmem_wdata;
            r_pmem_write   <= dcache_pmem_write;
            r_pmem_read    <= ~dcache_pmem_write;
            r_last_grant_d <= 1'b1;
        end else if (w_grant_i) begin
            r_pmem_address <= icache_pmem_address;
            r_pmem_write   <= 1'b0;
            r_pmem_read    <= 1'b1;
            r_last_grant_d <= 1'b0;
        end else if ((r_state != IDLE) && pmem_resp) begin
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
        end
    end

    assign pmem_read         = r_pmem_read;
    assign pmem_write        = r_pmem_write;
    assign pmem_address      = r_pmem_address;
    assign pmem_wdata        = r_pmem_wdata;
    assign icache_pmem_resp  = pmem_resp & (r_state == SERVE_I);
    assign dcache_pmem_resp  = pmem_resp & (r_state == SERVE_D);
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

endmodule
